// File: rtl/pattern_player.sv
// rtl/pattern_player.sv - four-voice step sequencer with gated square-wave tones OR-mixed to one speaker bit
module pattern_player #(
  parameter int STEP_DIV   = 6250000,
  parameter int GATE_DIV   = 3125000,
  parameter int TONE_HALF1 = 113636,
  parameter int TONE_HALF2 = 95556,
  parameter int TONE_HALF3 = 75843,
  parameter int TONE_HALF4 = 63776
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic [15:0] note1_i,
  input  logic [15:0] note2_i,
  input  logic [15:0] note3_i,
  input  logic [15:0] note4_i,
  output logic [3:0]  step_o,
  output logic        step_tick_o,
  output logic [3:0]  voice_on_o,
  output logic        playing_o,
  output logic        sound_o
);

  // Step timer counts 0..STEP_DIV-1 across one step; it reads 0 in LOAD.
  localparam int TW = $clog2(STEP_DIV);
  localparam logic [TW-1:0] GATE_END = TW'(GATE_DIV);
  localparam logic [TW-1:0] STEP_END = TW'(STEP_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, GATE, REST} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    step_q;
  logic          step_tick_q;
  logic          playing_q;
  logic [3:0]    voice_on_q;
  logic [3:0]    voice_on_d;
  logic [3:0]    square_w;
  logic          sound_q;

  // Next voice enables: sampled from the patterns in LOAD, dropped at gate end or on stop.
  // The gate is visible on timer values 1..GATE_DIV, i.e. exactly GATE_DIV cycles.
  always_comb begin
    voice_on_d = voice_on_q;
    if (!run_i) begin
      voice_on_d = '0;
    end else begin
      case (state_q)
        IDLE:    voice_on_d = '0;
        LOAD:    voice_on_d = {note4_i[step_q], note3_i[step_q], note2_i[step_q], note1_i[step_q]};
        GATE:    if (timer_q == GATE_END) voice_on_d = '0;
        default: ;
      endcase
    end
  end

  // Sequencer FSM: step timing, step index, tick and playing flags, registered voice enables.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      step_q      <= '0;
      step_tick_q <= 1'b0;
      playing_q   <= 1'b0;
      voice_on_q  <= '0;
    end else begin
      voice_on_q  <= voice_on_d;
      step_tick_q <= 1'b0;
      if (!run_i) begin
        state_q   <= IDLE;
        timer_q   <= '0;
        step_q    <= '0;
        playing_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q     <= LOAD;
            timer_q     <= '0;
            step_tick_q <= 1'b1;
            playing_q   <= 1'b1;
          end
          LOAD: begin
            state_q <= GATE;
            timer_q <= timer_q + TW'(1);
          end
          GATE, REST: begin
            if (timer_q == STEP_END) begin
              state_q     <= LOAD;
              timer_q     <= '0;
              step_q      <= step_q + 4'd1;
              step_tick_q <= 1'b1;
            end else begin
              timer_q <= timer_q + TW'(1);
              if (state_q == GATE && timer_q == GATE_END) state_q <= REST;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Per-voice tone generators; a tone restarts low at every gate because it is
  // cleared on the same edge that drops (or has not yet raised) its enable.
  for (genvar g = 0; g < 4; g++) begin : g_tone
    localparam int HALF = (g == 0) ? TONE_HALF1 :
                          (g == 1) ? TONE_HALF2 :
                          (g == 2) ? TONE_HALF3 : TONE_HALF4;
    localparam int CW = $clog2(HALF + 1);
    localparam logic [CW-1:0] CNT_END = CW'(HALF - 1);

    logic [CW-1:0] cnt_q;
    logic          sq_q;

    // Half-period counter toggling the square while the voice stays enabled.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        cnt_q <= '0;
        sq_q  <= 1'b0;
      end else if (voice_on_q[g] && voice_on_d[g]) begin
        if (cnt_q == CNT_END) begin
          cnt_q <= '0;
          sq_q  <= ~sq_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
        sq_q  <= 1'b0;
      end
    end

    assign square_w[g] = sq_q;
  end

  // Speaker mix: registered OR of the four squares.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sound_q <= 1'b0;
    else         sound_q <= |square_w;
  end

  assign step_o      = step_q;
  assign step_tick_o = step_tick_q;
  assign voice_on_o  = voice_on_q;
  assign playing_o   = playing_q;
  assign sound_o     = sound_q;

endmodule

// File: tb/tb_pattern_player.sv
// tb/tb_pattern_player.sv - randomized self-checking bench for pattern_player against a cycle-position model
module tb_pattern_player;

  localparam int STEP = 8;
  localparam int GATE = 4;
  localparam int HALF [4] = '{2, 3, 4, 5};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] note1 = '0, note2 = '0, note3 = '0, note4 = '0;
  logic [3:0]  step_o;
  logic        step_tick_o;
  logic [3:0]  voice_on_o;
  logic        playing_o;
  logic        sound_o;

  int checks = 0;
  int failures = 0;

  // Model state: position m_n in cycles since the LOAD of step 0 of the current run.
  bit         m_active = 1'b0;
  int         m_n = 0;
  logic [3:0] m_cap = '0;
  logic [3:0] m_prev_sq = '0;

  pattern_player #(
    .STEP_DIV(STEP), .GATE_DIV(GATE),
    .TONE_HALF1(2), .TONE_HALF2(3), .TONE_HALF3(4), .TONE_HALF4(5)
  ) dut (
    .clk_i(clk), .reset_i(reset), .run_i(run),
    .note1_i(note1), .note2_i(note2), .note3_i(note3), .note4_i(note4),
    .step_o(step_o), .step_tick_o(step_tick_o), .voice_on_o(voice_on_o),
    .playing_o(playing_o), .sound_o(sound_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Square level of each voice in the current cycle: gate cycle k sounds high when k/HALF is odd.
  function automatic logic [3:0] cur_sq();
    logic [3:0] r;
    int p;
    r = '0;
    if (m_active) begin
      p = m_n % STEP;
      if (p >= 1 && p <= GATE)
        for (int v = 0; v < 4; v++)
          if (m_cap[v]) r[v] = (((p - 1) / HALF[v]) % 2) == 1;
    end
    return r;
  endfunction

  // Reference model advance at each clock edge.
  always @(posedge clk or posedge reset) begin : mdl
    int s;
    if (reset) begin
      m_active  = 1'b0;
      m_n       = 0;
      m_cap     = '0;
      m_prev_sq = '0;
    end else begin
      m_prev_sq = cur_sq();
      if (m_active && (m_n % STEP) == 0) begin
        s = (m_n / STEP) % 16;
        m_cap = {note4[s], note3[s], note2[s], note1[s]};
      end
      if (!run) m_active = 1'b0;
      else if (!m_active) begin
        m_active = 1'b1;
        m_n = 0;
      end else m_n++;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin : chk
    int p;
    logic [3:0] e_step, e_von;
    logic e_tick;
    p = m_n % STEP;
    e_step = m_active ? 4'((m_n / STEP) % 16) : 4'd0;
    e_tick = m_active && (p == 0);
    e_von  = (m_active && p >= 1 && p <= GATE) ? m_cap : 4'd0;
    check("step", 32'(step_o), 32'(e_step));
    check("step_tick", 32'(step_tick_o), 32'(e_tick));
    check("voice_on", 32'(voice_on_o), 32'(e_von));
    check("playing", 32'(playing_o), 32'(m_active));
    check("sound", 32'(sound_o), 32'(|m_prev_sq));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    #2 reset = 1'b0;
    cyc(2);

    // Single voice on step 0 only.
    note1 = 16'h0001;
    run = 1'b1;
    cyc(20);

    // Async reset in the last gate cycle while the voice is sounding.
    run = 1'b0;
    cyc(2);
    run = 1'b1;
    cyc(5);
    #2 reset = 1'b1;
    #1;
    check("async_step", 32'(step_o), 32'd0);
    check("async_voice_on", 32'(voice_on_o), 32'd0);
    check("async_sound", 32'(sound_o), 32'd0);
    check("async_playing", 32'(playing_o), 32'd0);
    check("async_tick", 32'(step_tick_o), 32'd0);
    cyc(2);
    #2 reset = 1'b0;
    cyc(20);

    // All voices on every step, beyond one full 16-step wrap.
    run = 1'b0;
    cyc(2);
    note1 = 16'hFFFF; note2 = 16'hFFFF; note3 = 16'hFFFF; note4 = 16'hFFFF;
    run = 1'b1;
    cyc(135);

    // Pattern change during the gate takes effect only at the next step.
    run = 1'b0;
    note1 = '0; note3 = '0; note4 = '0; note2 = 16'h0002;
    cyc(2);
    run = 1'b1;
    cyc(3);
    note2 = 16'h0003;
    cyc(20);

    // Stop in the second gate cycle of step 5, then restart from step 0.
    run = 1'b0;
    cyc(2);
    note1 = 16'($urandom); note2 = 16'($urandom); note3 = 16'($urandom); note4 = 16'($urandom);
    run = 1'b1;
    cyc(43);
    run = 1'b0;
    cyc(3);
    run = 1'b1;
    cyc(20);

    // All four voices together on step 3.
    run = 1'b0;
    cyc(2);
    note1 = 16'($urandom) | 16'h0008; note2 = 16'($urandom) | 16'h0008;
    note3 = 16'($urandom) | 16'h0008; note4 = 16'($urandom) | 16'h0008;
    run = 1'b1;
    cyc(40);

    // Random run toggling and pattern rewrites.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) run = ~run;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: note1 = 16'($urandom);
          1: note2 = 16'($urandom);
          2: note3 = 16'($urandom);
          default: note4 = 16'($urandom);
        endcase
      end
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
